// File: rtl/gate_test_pkg.sv
// Shared definitions for the two-input gate exerciser: FSM encoding,
// Gray-ordered stimulus table and truth tables for the supported cells.
package gate_test_pkg;

  typedef enum logic [2:0] {
    GT_IDLE   = 3'd0,
    GT_APPLY  = 3'd1,
    GT_SETTLE = 3'd2,
    GT_SAMPLE = 3'd3,
    GT_DONE   = 3'd4
  } gt_state_t;

  // Entry i is the {a,b} pair driven at step i; wrapping 10 -> 00 also flips one bit.
  localparam logic [3:0][1:0] GT_GRAY_ORDER = {2'b10, 2'b11, 2'b01, 2'b00};

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic [1:0] gt_vector(input logic [1:0] idx);
    return GT_GRAY_ORDER[idx];
  endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// Pin-level link between the exerciser and a two-input gate under test.
interface gate_exerciser_if;
  logic a;
  logic b;
  logic f;

  modport master (output a, output b, input f);
  modport slave  (input a, input b, output f);
endinterface

// File: rtl/gate_exerciser_sync2.sv
// Two-flop synchroniser for a single level signal arriving from outside clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments give every flop the pre-edge value of its
  // neighbour; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// Drives Gray-ordered vectors into a two-input gate, samples its output after
// a settle window and accumulates mismatches against a truth table.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = TT_NOR,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned ITER   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  gate_exerciser_if.master        gate,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic [3:0]              fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  gt_state_t     state;
  logic [1:0]    idx;
  logic [15:0]   pass_cnt;
  logic [CW-1:0] settle_cnt;
  logic [1:0]    ab;
  logic          f_s;
  logic          mismatch;
  logic          last_pass;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gate.f),
    .q     (f_s)
  );

  assign gate.a    = ab[1];
  assign gate.b    = ab[0];
  assign mismatch  = (f_s != TRUTH[ab]);
  assign last_pass = (pass_cnt == 16'(ITER - 1));

  // Status flags are registered views of the state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == GT_APPLY) || (state == GT_SETTLE) || (state == GT_SAMPLE);
      done <= (state == GT_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GT_IDLE;
      idx        <= 2'd0;
      pass_cnt   <= 16'd0;
      settle_cnt <= '0;
      ab         <= 2'b00;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      fail_vec   <= 4'b0000;
    end else begin
      case (state)
        GT_IDLE: begin
          if (start) begin
            err_count <= 8'd0;
            fail_vec  <= 4'b0000;
            pass      <= 1'b0;
            idx       <= 2'd0;
            pass_cnt  <= 16'd0;
            state     <= GT_APPLY;
          end
        end

        GT_APPLY: begin
          ab         <= gt_vector(idx);
          settle_cnt <= CW'(SETTLE - 1);
          state      <= GT_SETTLE;
        end

        GT_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= GT_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        GT_SAMPLE: begin
          if (mismatch) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            fail_vec[ab] <= 1'b1;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            pass_cnt <= pass_cnt + 16'd1;
            state    <= last_pass ? GT_DONE : GT_APPLY;
          end else begin
            state <= GT_APPLY;
          end
        end

        GT_DONE: begin
          pass  <= (err_count == 8'd0);
          state <= GT_IDLE;
        end

        default: state <= GT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: NOR/NAND models, stuck-at outputs,
// saturation, ignored restarts and mid-run reset.
module tb_gate_exerciser;
  import gate_test_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      start;
  logic [2:0]      busy;
  logic [2:0]      done;
  logic [2:0]      pass;
  logic [2:0][7:0] err;
  logic [2:0][3:0] fv;
  logic            nor_on;

  int n_total = 0;
  int n_bad   = 0;
  int lat;
  int changes = 0;
  int viol    = 0;
  int done_seen;
  logic [1:0] prev_c = 2'b00;

  always #5 clk = ~clk;

  gate_exerciser_if if_a ();
  gate_exerciser_if if_b ();
  gate_exerciser_if if_c ();

  assign if_a.f = nor_on ? ~(if_a.a | if_a.b) : 1'b0;
  assign if_b.f = 1'b1;
  assign if_c.f = ~(if_c.a & if_c.b);

  gate_exerciser #(.TRUTH(TT_NOR), .SETTLE(4), .ITER(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .gate(if_a),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0])
  );

  gate_exerciser #(.TRUTH(TT_NOR), .SETTLE(4), .ITER(100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .gate(if_b),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1])
  );

  gate_exerciser #(.TRUTH(TT_NAND), .SETTLE(3), .ITER(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .gate(if_c),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]), .fail_vec(fv[2])
  );

  // Track every change of the NAND exerciser's {a,b}; each must flip one bit.
  always @(negedge clk) begin
    if ({if_c.a, if_c.b} != prev_c) begin
      changes <= changes + 1;
      if ($countones({if_c.a, if_c.b} ^ prev_c) > 1) viol <= viol + 1;
    end
    prev_c <= {if_c.a, if_c.b};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on unit u, then count edges until done (bounded by budget).
  // A second start pulse is injected at cycle 'poke' when poke is nonzero.
  task automatic run(input int u, input int budget, input int poke, output int n);
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[u] = 1'b0;
    n = 0;
    check("busy_lag", 32'(busy[u]), 32'd0);
    while (!done[u] && n < budget) begin
      @(negedge clk);
      n++;
      start[u] = (poke != 0 && n == poke);
      if (n == 1) check("busy_up", 32'(busy[u]), 32'd1);
    end
    start[u] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 3'b000;
    nor_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a",    32'(if_a.a), 32'd0);
    check("rst_b",    32'(if_a.b), 32'd0);
    check("rst_busy", 32'(busy),   32'd0);
    check("rst_done", 32'(done),   32'd0);
    check("rst_pass", 32'(pass),   32'd0);
    check("rst_err",  32'(err[0]), 32'd0);
    check("rst_fv",   32'(fv[0]),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NOR model, defaults: done 25 cycles after start, clean result.
    run(0, 100, 0, lat);
    check("nor_lat",  32'(lat),     32'd25);
    check("nor_pass", 32'(pass[0]), 32'd1);
    check("nor_err",  32'(err[0]),  32'd0);
    check("nor_fv",   32'(fv[0]),   32'd0);
    @(negedge clk);
    check("nor_done_pulse", 32'(done[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("nor_pass_held", 32'(pass[0]), 32'd1);
    check("nor_ab_held",   32'({if_a.a, if_a.b}), 32'd2);

    // f stuck at 0: only the 00 vector (expected 1) mismatches.
    nor_on = 1'b0;
    run(0, 100, 0, lat);
    check("s0_lat",  32'(lat),     32'd25);
    check("s0_err",  32'(err[0]),  32'd1);
    check("s0_fv",   32'(fv[0]),   32'd1);
    check("s0_pass", 32'(pass[0]), 32'd0);

    // f stuck at 1 over 100 passes: 300 mismatches saturate at 255.
    run(1, 3000, 0, lat);
    check("s1_lat",  32'(lat),     32'd2401);
    check("s1_err",  32'(err[1]),  32'd255);
    check("s1_fv",   32'(fv[1]),   32'd14);
    check("s1_pass", 32'(pass[1]), 32'd0);

    // NAND, SETTLE=3, ITER=2: 8 vectors of 5 cycles, single-bit steps only.
    run(2, 200, 0, lat);
    check("nand_lat",     32'(lat),     32'd41);
    check("nand_pass",    32'(pass[2]), 32'd1);
    check("nand_err",     32'(err[2]),  32'd0);
    check("nand_fv",      32'(fv[2]),   32'd0);
    check("nand_viol",    32'(viol),    32'd0);
    check("nand_changes", 32'(changes), 32'd7);

    // Start pulsed while busy has no effect on length or result.
    nor_on = 1'b1;
    run(0, 100, 7, lat);
    check("poke_lat",  32'(lat),     32'd25);
    check("poke_pass", 32'(pass[0]), 32'd1);
    repeat (30) @(negedge clk);
    check("poke_idle", 32'(busy[0]), 32'd0);

    // Reset during the second vector, with one mismatch already counted.
    nor_on = 1'b0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_ab",   32'({if_a.a, if_a.b}), 32'd1);
    check("pre_err",  32'(err[0]),  32'd1);
    check("pre_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_a",    32'(if_a.a),  32'd0);
    check("ar_b",    32'(if_a.b),  32'd0);
    check("ar_busy", 32'(busy[0]), 32'd0);
    check("ar_err",  32'(err[0]),  32'd0);
    check("ar_fv",   32'(fv[0]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) done_seen++;
    end
    check("ar_no_done", 32'(done_seen), 32'd0);

    nor_on = 1'b1;
    run(0, 100, 0, lat);
    check("fresh_lat",  32'(lat),     32'd25);
    check("fresh_pass", 32'(pass[0]), 32'd1);
    check("fresh_err",  32'(err[0]),  32'd0);
    check("fresh_fv",   32'(fv[0]),   32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Clocked stimulus/check engine for two-input switch-level gates. It drives `a`/`b` into a gate under test, samples the gate's `f` output, and compares it against a parameterised truth table. It sits on the opposite side of the gate's `a`,`b`→`f` interface: it produces `a`/`b` and consumes `f`. It is the standard self-check harness for `norgate` and sibling NAND/XOR cells on the test board.

## Interface
- `TRUTH`, default 4'b0001, expected `f` indexed by `{a,b}`; the default is NOR.
- `SETTLE`, default 4, cycles between applying a vector and sampling `f`; minimum 3.
- `ITER`, default 1, full passes over all four vectors; range 1..65535.

- `clk`, input, 1, sole clock, rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, begins a run when sampled high in IDLE.
- `a`, output, 1, gate input A, registered.
- `b`, output, 1, gate input B, registered.
- `f`, input, 1, gate output; asynchronous to `clk`.
- `busy`, output, 1, high from the first APPLY through the last SAMPLE.
- `done`, output, 1, one-cycle pulse when a run ends.
- `pass`, output, 1, high when the last run had zero mismatches; held until the next start.
- `err_count`, output, 8, mismatch count for the run; saturates at 255.
- `fail_vec`, output, 4, sticky per-`{a,b}` mismatch flags for the run.

## Operation
- `f` passes through a 2-flop synchroniser before any use. All compares use the synchronised value `f_s`.
- Vector order is Gray: `{a,b}` = 00, 01, 11, 10. Exactly one input toggles per step, and the step from 10 back to 00 on the next pass also toggles one bit.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
  - IDLE: if `start`, clear `err_count`, `fail_vec` and `pass`, reset the vector index and pass count, then go to APPLY.
  - APPLY: drive `a`/`b` from the vector index, load the settle counter with SETTLE−1, go to SETTLE.
  - SETTLE: decrement the counter. At 0, go to SAMPLE.
  - SAMPLE: if `f_s` ≠ `TRUTH[{a,b}]`, increment `err_count` (saturating) and set `fail_vec[{a,b}]`. Then advance the index.
    - If the index wraps and the pass count reaches ITER, go to DONE.
    - Otherwise go to APPLY.
  - DONE: pulse `done`, set `pass` = (`err_count`==0), return to IDLE.
- `start` is ignored outside IDLE.
- `a`/`b` hold their last vector after a run. They return to 0 only on reset.
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, FSM in IDLE, synchroniser flops at 0.
- Reset asserted mid-run aborts immediately to the reset values. No `done` pulse is produced, and no partial results are retained.

## Timing
- Each vector takes SETTLE+2 cycles: APPLY (1) + SETTLE (SETTLE) + SAMPLE (1).
- A run takes 4·ITER·(SETTLE+2) busy cycles. `done` is high one cycle later, in DONE.
- With `start` sampled at edge k:
  - `busy` and the first `a`/`b` values appear after edge k+1.
  - `done` is high in cycle k+1+4·ITER·(SETTLE+2).
- `pass` and `fail_vec` are valid in the same cycle as `done` and stay stable until the next accepted `start`. `err_count` is final from the last SAMPLE onward.
- The earliest SAMPLE falls SETTLE+1 edges after `a`/`b` change. With SETTLE ≥ 3, the 2-flop synchroniser has fully flushed the previous vector's `f`.
- `start` held high continuously back-to-back restarts after DONE→IDLE. The gap between runs is one IDLE cycle.

## Structure
- Shared package `gate_test_pkg` holds:
  - state enum `gt_state_t`
  - constant `GT_GRAY_ORDER` (00,01,11,10)
  - truth constants `TT_NOR`=4'b0001, `TT_NAND`=4'b0111, `TT_XOR`=4'b0110
- Sub-module `sync2`: a 2-flop synchroniser with asynchronous active-low reset, reused for `f`.
- Top-level holds the FSM, the 2-bit vector index, the 16-bit pass counter, the settle counter sized to SETTLE, and the result registers.

## Test plan
- `norgate` model on `f`, TRUTH=TT_NOR, SETTLE=4, ITER=1, pulse `start` → `done` 25 cycles after start, `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- `f` stuck at 0, default parameters → `err_count`=1, `fail_vec`=4'b0001, `pass`=0.
- `f` stuck at 1, ITER=100 → `fail_vec`=4'b1110, `err_count` saturates at 255 (not 300), `pass`=0.
- NAND model with TRUTH=TT_NAND, SETTLE=3, ITER=2 → `pass`=1. Also check that `a`/`b` never change two bits in one cycle across the full run, including the pass boundary.
- `start` pulsed while `busy` → ignored, and run length is unchanged at 4·ITER·(SETTLE+2).
- `rst_n` low during the second vector → same cycle: `a`=`b`=0, `busy`=0, `err_count`=0. After release, no `done` pulse appears, and a fresh `start` gives a clean run.
